// File: rtl/sipo_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx_if
// Description : Bundle of the serial-line input, frame configuration and
//               received-byte/status outputs of the UART receive deserializer.
//               master = the side driving the serial line (transmitter or bench)
//               slave  = the receiver (sipo_rx)
// Signals     : data_rx      serial line, idle high
//               parity_type  00 none, 01 odd, 10 even, 11 none
//               data_out     last received byte
//               active_flag  frame reception in progress
//               done_flag    one-cycle pulse when data_out/error flags update
//               parity_error parity mismatch of the last frame
//               stop_error   stop bit sampled low in the last frame
// Revision    : 1.0 - initial release
// ============================================================================
interface sipo_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 data_rx;
    logic [1:0]           parity_type;
    logic [DATA_BITS-1:0] data_out;
    logic                 active_flag;
    logic                 done_flag;
    logic                 parity_error;
    logic                 stop_error;

    modport master (
        output data_rx, parity_type,
        input  data_out, active_flag, done_flag, parity_error, stop_error
    );

    modport slave (
        input  data_rx, parity_type,
        output data_out, active_flag, done_flag, parity_error, stop_error
    );
endinterface
`default_nettype wire

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx
// Description : UART receive deserializer. Oversamples the serial line,
//               recovers start / LSB-first data / optional parity / stop, and
//               presents the byte plus parity and framing error flags.
// Ports       : baud_clk  clock, OVERSAMPLE x baud rate
//               reset     synchronous active-high reset
//               bus       sipo_rx_if.slave (line in, config, byte and flags out)
// Parameters  : OVERSAMPLE  clock cycles per bit (even, >= 4)
//               DATA_BITS   data bits per frame
// Options     : RX_MAJORITY_VOTE_EN - each bit decision is the 2-of-3 majority
//               of the synchronized line at mid-1, mid, mid+1.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  wire logic baud_clk,
    input  wire logic reset,
    sipo_rx_if.slave  bus
);
    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [c_TICK_W-1:0] c_BIT_END  = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0]  c_LAST_BIT = c_BIT_W'(DATA_BITS - 1);
`ifdef RX_MAJORITY_VOTE_EN
    // Decide one cycle later so the vote window (mid-1..mid+1) is complete.
    // All later bit decisions inherit the same one-cycle shift.
    localparam logic [c_TICK_W-1:0] c_START_TICK = c_TICK_W'(OVERSAMPLE / 2);
`else
    localparam logic [c_TICK_W-1:0] c_START_TICK = c_TICK_W'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_rx_prev;
    logic [c_TICK_W-1:0]   r_tick;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_mis;
    logic [DATA_BITS-1:0]  r_data_out;
    logic                  r_done;
    logic                  r_par_err;
    logic                  r_stop_err;

    logic w_fall;
    logic w_sample;
    logic w_mid;
    logic w_par_on;
    logic w_par_exp;
    logic w_tick_clr;
    logic w_frame_start;
    logic w_shift_en;
    logic w_par_en;
    logic w_done;

    // ------------------------------------------------------------------
    // Line synchronizer and edge history (all ones at reset = idle line)
    // ------------------------------------------------------------------
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= bus.data_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall = r_rx_prev & ~r_sync2;

`ifdef RX_MAJORITY_VOTE_EN
    logic r_rx_prev2;

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            r_rx_prev2 <= 1'b1;
        end else begin
            r_rx_prev2 <= r_rx_prev;
        end
    end

    assign w_sample = (r_rx_prev2 & r_rx_prev) | (r_rx_prev2 & r_sync2) | (r_rx_prev & r_sync2);
`else
    assign w_sample = r_sync2;
`endif

    assign w_mid     = (r_tick == c_BIT_END);
    assign w_par_on  = (bus.parity_type == 2'b01) || (bus.parity_type == 2'b10);
    // Even parity bit makes total ones even; odd makes it odd.
    assign w_par_exp = (bus.parity_type == 2'b10) ? ^r_shift : ~^r_shift;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tick_clr    = 1'b0;
        w_frame_start = 1'b0;
        w_shift_en    = 1'b0;
        w_par_en      = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                    w_tick_clr  = 1'b1;
                end
            end
            S_START: begin
                if (r_tick == c_START_TICK) begin
                    if (!w_sample) begin
                        w_state_nxt   = S_DATA;
                        w_tick_clr    = 1'b1;
                        w_frame_start = 1'b1;
                    end else begin
                        // Line back high at mid-start: glitch, not a frame.
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_mid) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt = w_par_on ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_mid) begin
                    w_par_en    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_mid) begin
                    // Leave at mid-stop so a back-to-back start edge is caught.
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            r_tick     <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_mis  <= 1'b0;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_done <= w_done;

            if (w_tick_clr || (r_state == S_IDLE)) begin
                r_tick <= '0;
            end else begin
                r_tick <= w_mid ? '0 : r_tick + c_TICK_W'(1);
            end

            if (w_frame_start) begin
                r_bit_cnt <= '0;
                r_par_mis <= 1'b0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
            end

            // LSB arrives first: shift right, newest bit enters at the MSB.
            if (w_shift_en) begin
                r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
            end

            if (w_par_en) begin
                r_par_mis <= (w_sample != w_par_exp);
            end

            if (w_done) begin
                r_data_out <= r_shift;
                r_stop_err <= ~w_sample;
                r_par_err  <= r_par_mis;
            end
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.active_flag  = (r_state != S_IDLE);
    assign bus.done_flag    = r_done;
    assign bus.parity_error = r_par_err;
    assign bus.stop_error   = r_stop_err;

endmodule
`default_nettype wire
